// File: rtl/uvmt_cv32e40s_obi_shim_pkg.sv
// Shared types and helpers for the cv32e40s OBI response-integrity shim.
//
// Contents:
//   RCHK_W            width of the OBI rchk bus
//   rchk_mode_e       runtime selection of how rchk_o is driven
//   pma_cfg_t         PMA region descriptor (layout matches cv32e40s_pkg)
//   PMA_R_DEFAULT     attributes used when no PMA region matches
//   NO_PMA_R_DEFAULT  attributes used when no PMA is configured at all
//   rchk_gen()        rchk computed from response data and error
package uvmt_cv32e40s_obi_shim_pkg;

  localparam int RCHK_W = 5;

  typedef enum logic [1:0] {
    RCHK_SCRAMBLE = 2'd0,
    RCHK_GENERATE = 2'd1,
    RCHK_PASSTHRU = 2'd2,
    RCHK_INVERT   = 2'd3
  } rchk_mode_e;

  // Region bounds are word addresses; a region covers low <= word < high.
  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        integrity;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_R_DEFAULT = '{
    word_addr_low : 32'h0, word_addr_high : 32'h0,
    main : 1'b0, bufferable : 1'b0, cacheable : 1'b0, integrity : 1'b0
  };

  localparam pma_cfg_t NO_PMA_R_DEFAULT = '{
    word_addr_low : 32'h0, word_addr_high : 32'h0,
    main : 1'b1, bufferable : 1'b0, cacheable : 1'b0, integrity : 1'b1
  };

  // One parity bit per rdata byte, with err in the top bit.
  function automatic logic [RCHK_W-1:0] rchk_gen(input logic [31:0] rdata,
                                                 input logic        err);
    return {err, ^rdata[31:24], ^rdata[23:16], ^rdata[15:8], ^rdata[7:0]};
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_obi_shim_fifo.sv
// 1-bit-wide pointer FIFO tracking outstanding OBI transactions.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i/data_i  write data_i at the write pointer
//   pop_i          retire the head entry (head is valid during the pop cycle)
//   data_o         head entry
//   count_o        number of stored entries
//   empty_o        count_o == 0
//   overflow_o     sticky: push while full without a pop
//   underflow_o    sticky: pop while empty
module uvmt_cv32e40s_obi_shim_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          data_i,
  output logic          data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the slot a full-FIFO push needs; a pop on an empty FIFO
  // retires nothing, but a push in that same cycle is still kept.
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty;

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + CW'(do_push) - CW'(do_pop);
    overflow_d  = overflow_q || (push_i && full && !pop_i);
    underflow_d = underflow_q || (pop_i && empty);
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; an entry is only read
  // once count_q says it was written, so its reset value is never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_o      = mem_q[rptr_q];
  assign count_o     = count_q;
  assign empty_o     = empty;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/uvmt_cv32e40s_obi_integrity_shim.sv
// OBI response-integrity shim between the OBI memory agent and one core OBI
// port. Each granted request is classified (PMA + debug-module region) as
// integrity or non-integrity and queued; each response pops the queue and
// rchk_o is driven from rchk_i or a generated value according to mode_i.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i, gnt_i, dbg_i, addr_i  address phase
//   rdata_i, rvalid_i, err_i, rchk_i  response phase from the agent
//   mode_i                     rchk_mode_e, sampled every cycle
//   rchk_o                     rchk to the core (combinational)
//   resp_integrity_o           head entry when outstanding, else 0
//   outstanding_o              in-flight count
//   overflow_o, underflow_o    sticky protocol error flags
//   inject_o                   rchk_o carries an injected error this cycle
//
// Optional feature: define UVMT_CV32E40S_OBI_SHIM_ERR_INJECT_EN to flip one
// rchk_o bit on every INJECT_PERIOD-th integrity response, rotating the bit.
module uvmt_cv32e40s_obi_integrity_shim
  import uvmt_cv32e40s_obi_shim_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int          PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t    PMA_CFG [PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
  parameter logic [31:0] DM_REGION_START = 32'hF000_0000,
  parameter logic [31:0] DM_REGION_END   = 32'hF000_3FFF,
  parameter int unsigned INJECT_PERIOD   = 16,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              gnt_i,
  input  logic              dbg_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       rdata_i,
  input  logic              rvalid_i,
  input  logic              err_i,
  input  logic [RCHK_W-1:0] rchk_i,
  input  logic [1:0]        mode_i,
  output logic [RCHK_W-1:0] rchk_o,
  output logic              resp_integrity_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              inject_o
);

  logic [31:0]       word_addr;
  pma_cfg_t          cfg;
  logic              in_dm, req_integrity;
  logic              head, empty;
  logic [RCHK_W-1:0] gen, rchk_mode;

  assign word_addr = {2'b00, addr_i[31:2]};

  // Scan from the top index down so the lowest matching region wins.
  if (PMA_NUM_REGIONS == 0) begin : g_no_pma
    assign cfg = NO_PMA_R_DEFAULT;
  end else begin : g_pma
    always_comb begin
      cfg = PMA_R_DEFAULT;
      for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
        if (word_addr >= PMA_CFG[i].word_addr_low &&
            word_addr <  PMA_CFG[i].word_addr_high) begin
          cfg = PMA_CFG[i];
        end
      end
    end
  end

  // Debug-module accesses made from debug mode never carry integrity.
  assign in_dm         = (addr_i >= DM_REGION_START) && (addr_i <= DM_REGION_END);
  assign req_integrity = cfg.integrity && !(dbg_i && in_dm);

  uvmt_cv32e40s_obi_shim_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_i && gnt_i),
    .pop_i       (rvalid_i),
    .data_i      (req_integrity),
    .data_o      (head),
    .count_o     (outstanding_o),
    .empty_o     (empty),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  assign resp_integrity_o = !empty && head;
  assign gen              = rchk_gen(rdata_i, err_i);

  // NOTE: every path assigns rchk_mode before any branch so no latch is
  // inferred when mode_i takes a value the case does not name.
  always_comb begin
    rchk_mode = rchk_i;
    unique case (rchk_mode_e'(mode_i))
      RCHK_SCRAMBLE: rchk_mode = resp_integrity_o ? rchk_i : ~rchk_i;
      RCHK_GENERATE: rchk_mode = resp_integrity_o ? gen : ~gen;
      RCHK_PASSTHRU: rchk_mode = rchk_i;
      RCHK_INVERT:   rchk_mode = ~rchk_i;
      default:       rchk_mode = rchk_i;
    endcase
  end

`ifdef UVMT_CV32E40S_OBI_SHIM_ERR_INJECT_EN
  localparam int unsigned INJ_CNT_W = (INJECT_PERIOD > 1) ? $clog2(INJECT_PERIOD) : 1;

  logic [INJ_CNT_W-1:0] inj_cnt_q, inj_cnt_d;
  logic [2:0]           inj_idx_q, inj_idx_d;
  logic [RCHK_W-1:0]    inj_mask;
  logic                 int_resp, inj_fire;

  assign int_resp = rvalid_i && resp_integrity_o;
  assign inj_fire = int_resp && (inj_cnt_q == INJ_CNT_W'(INJECT_PERIOD - 1));

  always_comb begin
    inj_cnt_d = inj_cnt_q;
    inj_idx_d = inj_idx_q;
    inj_mask  = '0;
    if (inj_fire) begin
      inj_mask[inj_idx_q] = 1'b1;
      inj_cnt_d           = '0;
      inj_idx_d           = (inj_idx_q == 3'(RCHK_W - 1)) ? 3'd0 : inj_idx_q + 3'd1;
    end else if (int_resp) begin
      inj_cnt_d = inj_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt_q <= '0;
      inj_idx_q <= '0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
      inj_idx_q <= inj_idx_d;
    end
  end

  assign rchk_o   = rchk_mode ^ inj_mask;
  assign inject_o = inj_fire;
`else
  assign rchk_o   = rchk_mode;
  assign inject_o = 1'b0;
`endif

endmodule
